imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be, one per line:
  DEPTH_BYTES, 64, target instruction memory size in bytes; multiple of 4.
  BASE_ADDR, 32'h0, byte address of the first written word; word-aligned.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  one-cycle request to begin a load.
  byte_valid  in  1  source presents byte_data.
  byte_data  in  8  stream byte.
  byte_ready  out  1  loader accepts byte this cycle; transfer occurs when byte_valid and byte_ready are both 1.
  mem_we  out  1  instruction-memory write strobe.
  mem_addr  out  32  byte address of the written word.
  mem_wdata  out  32  word to write; byte 0 of the stream maps to bits [7:0].
  busy  out  1  load in progress.
  done  out  1  load completed.
  error  out  1  declared length exceeds capacity.
  cpu_hold  out  1  holds the processor in reset while the program is not valid.

Function
REQ-003 Stream format SHALL be LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, little-endian per word.
REQ-004 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-005 IDLE: byte_ready=0; start=1 -> LEN_LO.
REQ-006 LEN_LO: byte_ready=1; on transfer, N[7:0]=byte_data -> LEN_HI.
REQ-007 LEN_HI: byte_ready=1; on transfer, N[15:8]=byte_data.
  - Full N=0 -> DONE.
  - N > DEPTH_BYTES/4 -> ERR.
  - Otherwise -> DATA, with addr=BASE_ADDR, byte index=0, words_left=N.
REQ-008 DATA: byte_ready=1; on each transfer, the byte SHALL be stored into word lane [8*idx+7:8*idx] and idx incremented; the 4th transfer -> WRITE.
REQ-009 No transfer SHALL occur in a cycle with byte_valid=0; state and idx SHALL hold across gaps of any length.
REQ-010 WRITE: byte_ready=0; mem_we=1 for exactly one cycle, with mem_addr=addr and mem_wdata=assembled word. Then words_left decrements:
  - words_left reaches 0 -> DONE.
  - Otherwise addr+=4, idx=0 -> DATA.
REQ-011 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-012 Peak throughput SHALL be one word per 5 cycles (4 transfers plus 1 write cycle).
REQ-013 busy SHALL be 1 in LEN_LO, LEN_HI, DATA and WRITE, and 0 otherwise.
REQ-014 DONE: done=1, cpu_hold=0, byte_ready=0; start=1 -> LEN_LO with done cleared and cpu_hold=1 in the next cycle.
REQ-015 ERR: error=1, cpu_hold=1, byte_ready=0, no writes; start=1 -> LEN_LO with error cleared.
REQ-016 cpu_hold SHALL be 1 in every state except DONE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 When start and byte_valid are both asserted in IDLE, DONE or ERR, that byte SHALL NOT be consumed, because byte_ready=0 in those states.
REQ-019 Address arithmetic SHALL be 32-bit; the last written address SHALL be BASE_ADDR+4*(N-1), never at or beyond BASE_ADDR+DEPTH_BYTES.

Reset
REQ-020 With rst=1 at a clock edge, the block SHALL enter IDLE, regardless of the current state (including mid-word or mid-length).
REQ-021 After that reset, outputs SHALL be: mem_we=0, byte_ready=0, busy=0, done=0, error=0, cpu_hold=1; internal addr, idx and words_left cleared.
REQ-022 A partially assembled word SHALL be discarded on reset and never written.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Basic load: start, then bytes 02 00 93 04 90 00 93 02 50 00 with byte_valid held high -> writes (0x0,0x00900493), then (0x4,0x00500293); done=1 and cpu_hold=0 exactly after the second write cycle.
  - Backpressure: same stream with byte_valid toggling 1,0,0,1 -> identical writes and order; no write before the 4th data byte of each word.
  - Empty program: length bytes 00 00 -> DONE on the cycle after LEN_HI; zero mem_we pulses.
  - Overflow: length 17 (11 00), DEPTH_BYTES=64 -> error=1, cpu_hold=1, no mem_we; a subsequent start plus a valid length-1 load succeeds with error cleared.
  - Reset mid-word: rst after 2 data bytes -> IDLE, no write, cpu_hold=1; a fresh load writes at BASE_ADDR.
  - start asserted during DATA -> ignored; the load completes with N writes.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a little-endian word count, then
// assembles and writes N 32-bit words starting at BASE_ADDR, holding the CPU until done.

module imem_loader_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 8'h00;
    else if (we) q <= d;
  end
endmodule

module imem_loader #(
  parameter int          DEPTH_BYTES = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);
  localparam int         NUM_LANES = 4;
  localparam logic [16:0] MAX_WORDS = 17'(DEPTH_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                        state, state_nxt;
  logic [7:0]                    len_lo;
  logic [15:0]                   len_full;
  logic [15:0]                   words_left;
  logic [31:0]                   addr;
  logic [1:0]                    idx;
  logic                          xfer;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     word;

  assign xfer     = byte_valid && byte_ready;
  assign len_full = {byte_data, len_lo};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (xfer) state_nxt = S_LEN_HI;
      S_LEN_HI:
        if (xfer) begin
          if (len_full == 16'd0)                 state_nxt = S_DONE;
          else if ({1'b0, len_full} > MAX_WORDS) state_nxt = S_ERR;
          else                                   state_nxt = S_DATA;
        end
      S_DATA:
        if (xfer && idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE:
        state_nxt = (words_left == 16'd1) ? S_DONE : S_DATA;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // outputs are purely a function of state
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:
        error = 1'b1;
      default: ;
    endcase
  end

  // length capture, address and word counters
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= 8'h00;
      addr       <= 32'h0;
      idx        <= 2'd0;
      words_left <= 16'd0;
    end else begin
      case (state)
        S_LEN_LO:
          if (xfer) len_lo <= byte_data;
        S_LEN_HI:
          if (xfer) begin
            addr       <= BASE_ADDR;
            idx        <= 2'd0;
            words_left <= len_full;
          end
        S_DATA:
          if (xfer) idx <= idx + 2'd1;
        S_WRITE: begin
          words_left <= words_left - 16'd1;
          idx        <= 2'd0;
          // leave addr on the last word so it never points past the image
          if (words_left != 16'd1) addr <= addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // one byte register per word lane; reset discards any partial word
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = (state == S_DATA) && xfer && (idx == 2'(g));
    imem_loader_lane u_lane (
      .clk (clk),
      .rst (rst),
      .we  (lane_we[g]),
      .d   (byte_data),
      .q   (word[g])
    );
  end

  assign mem_addr  = addr;
  assign mem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams and checks writes and
// status flags against hand-computed values.

module tb_imem_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks;
  int failures;

  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  int          wr_cnt;
  int          base;

  imem_loader #(.DEPTH_BYTES(64), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write log: a write happens at the edge that ends a cycle with mem_we=1
  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we && wr_cnt < 64) begin
      wa[wr_cnt] <= mem_addr;
      wd[wr_cnt] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive a byte with optional leading idle cycles; returns 1ns after the accepting edge
  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    chk("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    @(posedge clk); #1;

    // basic load, byte_valid held high
    base = wr_cnt;
    pulse_start();
    send(8'h02, 0); send(8'h00, 0);
    send_word(32'h00900493, 0);
    send(8'h93, 0); send(8'h02, 0); send(8'h50, 0); send(8'h00, 0);
    @(negedge clk);
    chk("basic_we2",    {31'd0, mem_we}, 32'd1);
    chk("basic_addr2",  mem_addr,        32'h4);
    chk("basic_data2",  mem_wdata,       32'h00500293);
    chk("basic_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("basic_done",     {31'd0, done},     32'd1);
    chk("basic_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("basic_busy",     {31'd0, busy},     32'd0);
    chk("basic_nwr",      wr_cnt - base,     32'd2);
    chk("basic_wa0",      wa[base],          32'h0);
    chk("basic_wd0",      wd[base],          32'h00900493);
    chk("basic_wa1",      wa[base+1],        32'h4);
    chk("basic_wd1",      wd[base+1],        32'h00500293);
    @(posedge clk); #1;

    // backpressure: two idle cycles between bytes; restart from DONE
    base = wr_cnt;
    pulse_start();
    @(negedge clk);
    chk("restart_done_clr", {31'd0, done},     32'd0);
    chk("restart_hold",     {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    send(8'h02, 2); send(8'h00, 2);
    send(8'h93, 2); send(8'h04, 2); send(8'h90, 2);
    chk("bp_no_early_wr0", wr_cnt - base, 32'd0);
    send(8'h00, 2);
    send(8'h93, 2); send(8'h02, 2); send(8'h50, 2);
    chk("bp_no_early_wr1", wr_cnt - base, 32'd1);
    send(8'h00, 2);
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_nwr",  wr_cnt - base, 32'd2);
    chk("bp_wa0",  wa[base],      32'h0);
    chk("bp_wd0",  wd[base],      32'h00900493);
    chk("bp_wa1",  wa[base+1],    32'h4);
    chk("bp_wd1",  wd[base+1],    32'h00500293);
    @(posedge clk); #1;

    // empty program
    base = wr_cnt;
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("empty_done",     {31'd0, done},     32'd1);
    chk("empty_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    @(posedge clk); #1;
    chk("empty_nwr", wr_cnt - base, 32'd0);

    // overflow: 17 words exceeds 16-word capacity
    base = wr_cnt;
    pulse_start();
    send(8'h11, 0); send(8'h00, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ovf_error", {31'd0, error},      32'd1);
      chk("ovf_hold",  {31'd0, cpu_hold},   32'd1);
      chk("ovf_ready", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("ovf_nwr", wr_cnt - base, 32'd0);
    // start with a valid byte in ERR: the byte must not be taken as length
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    chk("ovf_err_clr", {31'd0, error}, 32'd0);
    chk("ovf_busy",    {31'd0, busy},  32'd1);
    @(posedge clk); #1;
    send(8'h01, 0); send(8'h00, 0);
    send_word(32'h44332211, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ovf_rec_done", {31'd0, done}, 32'd1);
    chk("ovf_rec_nwr",  wr_cnt - base, 32'd1);
    chk("ovf_rec_wa",   wa[base],      32'h0);
    chk("ovf_rec_wd",   wd[base],      32'h44332211);
    @(posedge clk); #1;

    // reset mid-word
    base = wr_cnt;
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'hDE, 0); send(8'hAD, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy",  {31'd0, busy},       32'd0);
    chk("mid_hold",  {31'd0, cpu_hold},   32'd1);
    chk("mid_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_done",  {31'd0, done},       32'd0);
    repeat (2) @(posedge clk); #1;
    chk("mid_nwr", wr_cnt - base, 32'd0);
    pulse_start();
    send(8'h01, 0); send(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    @(posedge clk); #1;
    chk("mid_fresh_nwr", wr_cnt - base, 32'd1);
    chk("mid_fresh_wa",  wa[base],      32'h0);
    chk("mid_fresh_wd",  wd[base],      32'hDEADBEEF);

    // start during DATA is ignored
    base = wr_cnt;
    pulse_start();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0);
    start = 1'b1;
    send(8'h03, 0);
    start = 1'b0;
    send(8'h04, 0);
    send_word(32'h08070605, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sd_done", {31'd0, done}, 32'd1);
    chk("sd_nwr",  wr_cnt - base, 32'd2);
    chk("sd_wd0",  wd[base],      32'h04030201);
    chk("sd_wa1",  wa[base+1],    32'h4);
    chk("sd_wd1",  wd[base+1],    32'h08070605);
    @(posedge clk); #1;

    // full-capacity load: 16 words, last address 0x3C
    base = wr_cnt;
    pulse_start();
    send(8'h10, 0); send(8'h00, 0);
    for (int i = 0; i < 16; i++) send_word(32'hA5000000 | 32'(i), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_done",  {31'd0, done},  32'd1);
    chk("full_error", {31'd0, error}, 32'd0);
    chk("full_nwr",   wr_cnt - base,  32'd16);
    chk("full_wa_last", wa[base+15],  32'h3C);
    chk("full_wd_last", wd[base+15],  32'hA500000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
